pio_debounced_edge_irq: RTL and testbench

//  Parametrised Avalon-MM input PIO for board pushbuttons/switches. Synchronises WIDTH async inputs,

---
 rtl/pio_debounced_pkg.sv | 15 +
 rtl/pio_debounced_edge_irq_if.sv | 28 ++
 rtl/pio_debounce_bit.sv | 57 +++++
 rtl/pio_debounced_edge_irq.sv | 101 ++++++++++
 tb/tb_pio_debounced_edge_irq.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/pio_debounced_pkg.sv
// Shared constants for the debounced edge-capturing input PIO.
// Register word addresses and bus widths.
package pio_debounced_pkg;

    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DATA_W = 32;

    localparam logic [ADDR_W-1:0] ADDR_DATA    = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_RAW     = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_IRQMASK = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_CAPTURE = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_RISE_EN = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_FALL_EN = 3'd5;

endpackage

// File: rtl/pio_debounced_edge_irq_if.sv
// Avalon-MM slave bus bundle for the debounced input PIO.
// The master drives address/strobes/writedata; the slave returns registered readdata.
interface pio_debounced_edge_irq_if;
    import pio_debounced_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/pio_debounce_bit.sv
// One input bit: synchroniser chain, stability counter and debounced flop.
// changed_o pulses on the cycle before deb_o takes the new raw value.
module pio_debounce_bit #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned DEBOUNCE_CYC = 16,
    parameter bit          RESET_VAL    = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic in_i,
    output logic raw_o,
    output logic deb_o,
    output logic changed_o
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYC - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   deb_q, deb_d;
    logic                   raw;

    assign raw = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], in_i};
        cnt_d     = cnt_q;
        deb_d     = deb_q;
        changed_o = 1'b0;
        if (raw == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntLast) begin
            deb_d     = raw;
            cnt_d     = '0;
            changed_o = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            cnt_q  <= '0;
            deb_q  <= RESET_VAL;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            deb_q  <= deb_d;
        end
    end

    assign raw_o = raw;
    assign deb_o = deb_q;

endmodule

// File: rtl/pio_debounced_edge_irq.sv
// Avalon-MM input PIO: per-bit debounce, enabled rise/fall edge capture (W1C)
// and a masked level interrupt.
module pio_debounced_edge_irq
    import pio_debounced_pkg::*;
#(
    parameter int unsigned      WIDTH        = 4,
    parameter int unsigned      SYNC_STAGES  = 2,
    parameter int unsigned      DEBOUNCE_CYC = 16,
    parameter logic [WIDTH-1:0] RESET_LEVEL  = '0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    pio_debounced_edge_irq_if.slave  bus,
    input  logic [WIDTH-1:0]         in_port,
    output logic                     irq
);

    logic [WIDTH-1:0] raw, deb, changed, rise, fall;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] capture_q, capture_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [DATA_W-1:0] readdata_q, readdata_d;
    logic [WIDTH-1:0] wdata;
    logic             wr;
    logic             unused_wdata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pio_debounce_bit #(
            .SYNC_STAGES  (SYNC_STAGES),
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .RESET_VAL    (RESET_LEVEL[i])
        ) u_deb (
            .clk_i     (clk),
            .rst_ni    (reset_n),
            .in_i      (in_port[i]),
            .raw_o     (raw[i]),
            .deb_o     (deb[i]),
            .changed_o (changed[i])
        );
    end

    assign wr           = bus.chipselect & ~bus.write_n;
    assign wdata        = bus.writedata[WIDTH-1:0];
    assign unused_wdata = ^bus.writedata;

    // A change always inverts deb, so the current level tells the edge direction.
    assign rise = changed & ~deb & rise_en_q;
    assign fall = changed & deb & fall_en_q;

    always_comb begin
        irq_mask_d = irq_mask_q;
        rise_en_d  = rise_en_q;
        fall_en_d  = fall_en_q;
        capture_d  = capture_q;
        if (wr) begin
            case (bus.address)
                ADDR_IRQMASK: irq_mask_d = wdata;
                ADDR_CAPTURE: capture_d  = capture_q & ~wdata;
                ADDR_RISE_EN: rise_en_d  = wdata;
                ADDR_FALL_EN: fall_en_d  = wdata;
                default: ;
            endcase
        end
        // New edges are ORed in after the clear so a coincident event survives.
        capture_d = capture_d | rise | fall;
    end

    always_comb begin
        readdata_d = '0;
        case (bus.address)
            ADDR_DATA:    readdata_d = DATA_W'(deb);
            ADDR_RAW:     readdata_d = DATA_W'(raw);
            ADDR_IRQMASK: readdata_d = DATA_W'(irq_mask_q);
            ADDR_CAPTURE: readdata_d = DATA_W'(capture_q);
            ADDR_RISE_EN: readdata_d = DATA_W'(rise_en_q);
            ADDR_FALL_EN: readdata_d = DATA_W'(fall_en_q);
            default:      readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask_q <= '0;
            capture_q  <= '0;
            rise_en_q  <= '1;
            fall_en_q  <= '0;
            readdata_q <= '0;
        end else begin
            irq_mask_q <= irq_mask_d;
            capture_q  <= capture_d;
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            readdata_q <= readdata_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign irq          = |(capture_q & irq_mask_q);

endmodule

// File: tb/tb_pio_debounced_edge_irq.sv
// Directed bench for pio_debounced_edge_irq: register table plus edge/debounce/reset sequences.
module tb_pio_debounced_edge_irq;

    typedef struct {
        bit        wr;
        bit [2:0]  addr;
        bit [31:0] wdata;
        bit [31:0] exp;
        string     name;
    } reg_vec_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] in_port = 4'h0;
    logic       irq;
    int         checks = 0;
    int         errors = 0;

    pio_debounced_edge_irq_if bus ();

    pio_debounced_edge_irq #(
        .WIDTH        (4),
        .SYNC_STAGES  (2),
        .DEBOUNCE_CYC (16),
        .RESET_LEVEL  (4'h0)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .in_port (in_port),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, input string name, input logic [31:0] exp);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        check(name, bus.readdata, exp);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    reg_vec_t vecs[$];

    initial begin
        vecs = '{
            '{1'b0, 3'd0, 32'h0,         32'h0, "rst DATA"},
            '{1'b0, 3'd1, 32'h0,         32'h0, "rst RAW"},
            '{1'b0, 3'd2, 32'h0,         32'h0, "rst IRQMASK"},
            '{1'b0, 3'd3, 32'h0,         32'h0, "rst CAPTURE"},
            '{1'b0, 3'd4, 32'h0,         32'hF, "rst RISE_EN"},
            '{1'b0, 3'd5, 32'h0,         32'h0, "rst FALL_EN"},
            '{1'b0, 3'd6, 32'h0,         32'h0, "rst addr6"},
            '{1'b0, 3'd7, 32'h0,         32'h0, "rst addr7"},
            '{1'b1, 3'd2, 32'hFFFF_FFFF, 32'h0, ""},
            '{1'b0, 3'd2, 32'h0,         32'hF, "IRQMASK width"},
            '{1'b1, 3'd0, 32'h0000_000F, 32'h0, ""},
            '{1'b0, 3'd0, 32'h0,         32'h0, "DATA read-only"},
            '{1'b1, 3'd5, 32'h0000_000A, 32'h0, ""},
            '{1'b0, 3'd5, 32'h0,         32'hA, "FALL_EN rw"},
            '{1'b1, 3'd4, 32'h0000_0003, 32'h0, ""},
            '{1'b0, 3'd4, 32'h0,         32'h3, "RISE_EN rw"},
            '{1'b1, 3'd6, 32'h0000_000F, 32'h0, ""},
            '{1'b0, 3'd6, 32'h0,         32'h0, "addr6 ignored"},
            '{1'b1, 3'd2, 32'h0,         32'h0, ""},
            '{1'b1, 3'd4, 32'h0000_000F, 32'h0, ""},
            '{1'b1, 3'd5, 32'h0,         32'h0, ""},
            '{1'b0, 3'd4, 32'h0,         32'hF, "RISE_EN restore"}
        };

        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;

        // Test 1: reset values
        #12;
        check("rst readdata", bus.readdata, 32'h0);
        check("rst irq", {31'h0, irq}, 32'h0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wdata);
            else            bus_read(vecs[i].addr, vecs[i].name, vecs[i].exp);
        end

        // Test 2: clean rising edge on bit0, exact latency via irq
        bus_write(3'd2, 32'h1);
        in_port = 4'h1;
        cycles(17);
        check("irq before latency", {31'h0, irq}, 32'h0);
        cycles(1);
        check("irq at 2+16", {31'h0, irq}, 32'h1);
        bus_read(3'd0, "DATA bit0", 32'h1);
        bus_read(3'd1, "RAW bit0", 32'h1);
        bus_read(3'd3, "CAPTURE bit0", 32'h1);
        bus_write(3'd3, 32'h1);
        check("irq after W1C", {31'h0, irq}, 32'h0);
        bus_read(3'd3, "CAPTURE cleared", 32'h0);

        // Test 3: bounce on bit1 is rejected
        in_port = 4'h3;
        cycles(10);
        in_port = 4'h1;
        cycles(3);
        in_port = 4'h3;
        cycles(10);
        in_port = 4'h1;
        cycles(30);
        bus_read(3'd0, "bounce DATA", 32'h1);
        bus_read(3'd3, "bounce CAPTURE", 32'h0);

        // Test 4: falling-only enable on bit2
        bus_write(3'd4, 32'h0);
        bus_write(3'd5, 32'h4);
        in_port = 4'h5;
        cycles(20);
        bus_read(3'd0, "bit2 high DATA", 32'h5);
        bus_read(3'd3, "rise ignored", 32'h0);
        in_port = 4'h1;
        cycles(20);
        bus_read(3'd3, "fall captured", 32'h4);
        bus_write(3'd3, 32'h4);
        bus_read(3'd3, "fall cleared", 32'h0);

        // Test 5: edge on bit3 coincides with W1C of bit3
        bus_write(3'd4, 32'hF);
        in_port = 4'h9;
        cycles(17);
        bus_write(3'd3, 32'h8);
        bus_read(3'd3, "set beats clear", 32'h8);

        // Test 6: async reset mid-count with pending irq
        bus_write(3'd2, 32'h3);
        bus_write(3'd5, 32'h3);
        in_port = 4'hA;
        cycles(20);
        bus_write(3'd3, 32'h8);
        bus_read(3'd3, "pre-reset CAPTURE", 32'h3);
        check("pre-reset irq", {31'h0, irq}, 32'h1);
        in_port = 4'h0;
        cycles(5);
        #2;
        reset_n = 1'b0;
        #1;
        check("async irq", {31'h0, irq}, 32'h0);
        check("async readdata", bus.readdata, 32'h0);
        check("async CAPTURE", {28'h0, dut.capture_q}, 32'h0);
        check("async IRQMASK", {28'h0, dut.irq_mask_q}, 32'h0);
        check("async DATA", {28'h0, dut.deb}, 32'h0);
        #3;
        reset_n = 1'b1;
        cycles(1);
        for (int i = 0; i < 8; i++) begin
            bus_read(vecs[i].addr, {"post-", vecs[i].name}, vecs[i].exp);
        end
        in_port = 4'h2;
        cycles(20);
        bus_read(3'd3, "post-reset edge", 32'h2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
